multi_dma_stream_arb: RTL and testbench
=======================================

# multi_dma_stream_arb

Packet-level round-robin merger placed directly downstream of the multi-channel DMA read engine. It consumes the CH per-channel read streams (val/rdy/eof/data) and serialises them onto one tagged output stream for a single consumer, such as a packer or a write-back DMA. Once a channel is granted, it owns the output until its eof beat is accepted, so packets are never interleaved. The output is fully registered, with one register stage carrying channel ID and beat index.

## Interface
Parameters:
- CH, 5: number of input channels (≥1)
- DW, 32: data width per beat
- CW, $clog2(CH+1): channel-tag width
- LW, 24: beat-index counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low; sampled on rising clk
- ch_en  in  [CH-1:0]  per-channel arbitration enable
- in_val  in  [CH-1:0]  per-channel beat valid
- in_rdy  out  [CH-1:0]  per-channel beat ready
- in_eof  in  [CH-1:0]  marks last beat of a packet
- in_d  in  [CH-1:0][DW-1:0]  per-channel beat data
- out_val  out  1  output beat valid (registered)
- out_rdy  in  1  consumer ready
- out_eof  out  1  last beat of current packet
- out_ch  out  [CW-1:0]  source channel of current beat
- out_idx  out  [LW-1:0]  beat index within the packet, starting at 0
- out_d  out  [DW-1:0]  beat data
- busy  out  1  a channel is currently granted
- pkt_done  out  1  one-cycle pulse when the eof beat is accepted at the output

## Operation
State machine:
- IDLE:
  - Evaluate req = in_val & ch_en.
  - If req≠0, grant the first set bit searching from (last_gnt+1) mod CH, wrapping.
  - Register gnt, load beat counter to 0, go to LOCK.
  - in_rdy is all-zero in IDLE.
- LOCK:
  - in_rdy[gnt] = !out_val || out_rdy. All other in_rdy bits = 0.
  - Accepting a beat (in_val[gnt] & in_rdy[gnt]) loads the output register with d, eof, ch=gnt, idx=counter, then increments the counter.
  - Accepting a beat with in_eof set returns the FSM to IDLE and sets last_gnt = gnt.
- ch_en only affects new grants. Clearing ch_en[gnt] mid-packet does not abort the packet.
- The beat counter saturates at 2^LW−1 and never wraps. Beats past saturation repeat idx = all-ones.
- busy = (state == LOCK).
- pkt_done = out_val & out_rdy & out_eof.
- Output register: holds its contents while out_val & !out_rdy. It clears out_val when drained with no new input beat.

Reset values:
- state = IDLE, last_gnt = CH−1 (so channel 0 has first priority).
- out_val = 0, out_eof = 0, out_ch = 0, out_idx = 0, out_d = 0.
- in_rdy = 0, busy = 0, pkt_done = 0.

## Timing
- Arbitration: one cycle in IDLE. The first beat can be accepted in the cycle after the grant, and appears on out_val one cycle after acceptance.
- Steady-state throughput within a packet is one beat per cycle when out_rdy=1.
- Between packets there is exactly one bubble cycle (the IDLE arbitration cycle), even if the same channel requests again.
- in_rdy depends combinationally on out_rdy, gnt and out_val only. It never depends on in_val.
- in_eof with in_val low is ignored. Single-beat packets (eof on beat 0) are legal: out_idx = 0 and out_eof = 1.
- Back-pressure: when out_rdy is low while out_val is high, all output fields stay stable and in_rdy[gnt] = 0.
- Reset mid-packet: synchronous. The next cycle is IDLE with out_val = 0 and the partial packet is discarded. The upstream DMA is reset by its own domain logic.
- CH = 1: the arbiter degenerates. Only the IDLE/LOCK bubble remains.

## Structure
- Put the FSM state enum (IDLE, LOCK) and the round-robin next-grant function in a shared package, e.g. dma_stream_pkg. The grant function takes req and last_gnt and returns the grant index; it is reused by other arbiters.
- One natural sub-module, rr_pick: purely combinational round-robin priority selector, parameterised by CH.
- The output register and the beat counter stay in the top module.

## Test plan
- Single channel: ch1 sends 4 beats D0..D3, eof on D3, out_rdy=1. Expect out_ch=1, out_idx 0..3, out_eof only on idx 3, pkt_done pulses once, 1-cycle arbitration gap before the first input accept.
- Round-robin: ch0, ch2 and ch4 all request continuously with 2-beat packets. Expect the grant order 0, 2, 4, 0, … with no interleaving and a single bubble between packets.
- Back-pressure: out_rdy low for 3 cycles mid-packet. Expect out_d, out_idx and out_eof held, in_rdy[gnt]=0, no beat lost or duplicated.
- Mask: clear ch_en[0] during a ch0 packet. Expect the packet to complete. Then, with ch0 and ch1 requesting, expect only ch1 to be granted.
- Saturation: LW=3, 10-beat packet. Expect out_idx 0..7, then 7, 7.
- Reset: assert rst_n=0 for one cycle mid-packet. Expect out_val=0, busy=0, and the next grant to go to ch0 when all channels request.

Source files
------------

// File: rtl/multi_dma_stream_arb_pkg.sv
// Shared definitions for the DMA stream arbiters.
//   state_t        : two-state packet arbitration FSM (IDLE arbitrates, LOCK streams a packet)
//   rr_next_grant  : round-robin next-grant search, reusable by any arbiter up to RR_MAX_CH requesters
package multi_dma_stream_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Upper bound on requesters the shared grant function can serve.
    localparam int unsigned RR_MAX_CH = 64;
    localparam int unsigned RR_IW     = 6;

    // Returns the first requesting index found when searching upward from
    // (last_gnt + 1) mod n, wrapping. With no request pending it returns
    // last_gnt, which callers ignore because they also see req == 0.
    function automatic int unsigned rr_next_grant(
        input logic [RR_MAX_CH-1:0] req,
        input int unsigned          n,
        input int unsigned          last_gnt
    );
        int unsigned idx;
        logic        found;
        rr_next_grant = last_gnt;
        found         = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_CH; k++) begin
            if (k <= n && !found) begin
                // last_gnt < n and k <= n, so one subtraction is enough to wrap.
                idx = last_gnt + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[RR_IW-1:0]]) begin
                    rr_next_grant = idx;
                    found         = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/multi_dma_stream_arb_rr_pick.sv
// rr_pick: purely combinational round-robin priority selector.
// Ports:
//   req      in  [CH-1:0]  request vector
//   last_gnt in  [CW-1:0]  index granted most recently (search starts one above it)
//   gnt      out [CW-1:0]  selected index (meaningful only when any = 1)
//   any      out 1         at least one request is pending
module rr_pick
    import multi_dma_stream_arb_pkg::*;
#(
    parameter int CH = 5,
    parameter int CW = $clog2(CH + 1)
) (
    input  logic [CH-1:0] req,
    input  logic [CW-1:0] last_gnt,
    output logic [CW-1:0] gnt,
    output logic          any
);

    logic [RR_MAX_CH-1:0] req_ext;
    int unsigned          pick;

    always_comb begin
        req_ext         = '0;
        req_ext[CH-1:0] = req;
        pick            = rr_next_grant(req_ext, CH, 32'(last_gnt));
        gnt             = CW'(pick);
        any             = |req;
    end

endmodule

// File: rtl/multi_dma_stream_arb.sv
// multi_dma_stream_arb: packet-level round-robin merger of CH DMA read streams
// onto one tagged, fully registered output stream. A granted channel owns the
// output until its eof beat is accepted, so packets never interleave.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ch_en   [CH-1:0]      per-channel arbitration enable (new grants only)
//   in_val/in_rdy/in_eof  per-channel beat handshake and end-of-packet marker
//   in_d    [CH][DW]      per-channel beat data
//   out_val/out_rdy       registered output handshake
//   out_eof/out_ch/out_idx/out_d  registered beat: last flag, source channel,
//                         beat index in packet (saturating), data
//   busy                  a channel currently holds the grant
//   pkt_done              pulse when the eof beat leaves the output register
module multi_dma_stream_arb
    import multi_dma_stream_arb_pkg::*;
#(
    parameter int CH = 5,
    parameter int DW = 32,
    parameter int CW = $clog2(CH + 1),
    parameter int LW = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH-1:0]          ch_en,
    input  logic [CH-1:0]          in_val,
    output logic [CH-1:0]          in_rdy,
    input  logic [CH-1:0]          in_eof,
    input  logic [CH-1:0][DW-1:0]  in_d,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic                   out_eof,
    output logic [CW-1:0]          out_ch,
    output logic [LW-1:0]          out_idx,
    output logic [DW-1:0]          out_d,
    output logic                   busy,
    output logic                   pkt_done
);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] gnt;
    logic [CW-1:0] last_gnt;
    logic [CW-1:0] pick_gnt;
    logic          pick_any;
    logic [CH-1:0] req;
    logic [LW-1:0] beat_cnt;
    logic          out_free;
    logic          accept;
    logic          sel_eof;
    logic [DW-1:0] sel_d;

    assign req = in_val & ch_en;

    rr_pick #(
        .CH (CH),
        .CW (CW)
    ) u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt),
        .any      (pick_any)
    );

    // Input side: only the granted channel sees ready, and only while the
    // output register is empty or draining this cycle. Ready never looks at
    // in_val so upstream can wait on it without a combinational loop.
    always_comb begin
        in_rdy   = '0;
        sel_eof  = 1'b0;
        sel_d    = '0;
        out_free = !out_val || out_rdy;
        for (int i = 0; i < CH; i++) begin
            if (gnt == CW'(i)) begin
                in_rdy[i] = (state == LOCK) && out_free;
                sel_eof   = in_eof[i];
                sel_d     = in_d[i];
            end
        end
        accept = |(in_val & in_rdy);
    end

    // Next state: IDLE lasts exactly one cycle whenever anything requests;
    // LOCK ends on the accepted eof beat, which forces the inter-packet bubble.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = LOCK;
            LOCK:    if (accept && sel_eof) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant bookkeeping and the saturating beat counter. last_gnt resets to
    // CH-1 so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= '0;
            last_gnt <= CW'(CH - 1);
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt      <= pick_gnt;
                beat_cnt <= '0;
            end
            if (accept) begin
                if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + LW'(1);
                end
                if (sel_eof) begin
                    last_gnt <= gnt;
                end
            end
        end
    end

    // Output register: loads on an accepted beat, otherwise empties once the
    // consumer takes it, and holds every field while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_val <= 1'b0;
            out_eof <= 1'b0;
            out_ch  <= '0;
            out_idx <= '0;
            out_d   <= '0;
        end else if (accept) begin
            out_val <= 1'b1;
            out_eof <= sel_eof;
            out_ch  <= gnt;
            out_idx <= beat_cnt;
            out_d   <= sel_d;
        end else if (out_rdy) begin
            out_val <= 1'b0;
        end
    end

    assign busy     = (state == LOCK);
    assign pkt_done = out_val && out_rdy && out_eof;

endmodule

// File: tb/tb_multi_dma_stream_arb.sv
// Self-checking bench for multi_dma_stream_arb (CH=5, DW=32, LW=3).
// Randomised per-channel packet sources feed the DUT; a reference model that
// follows the arbitration rules pushes each expected output beat into a
// scoreboard queue, and a monitor compares it whenever the DUT presents it.
module tb_multi_dma_stream_arb;

    localparam int CH     = 5;
    localparam int DW     = 32;
    localparam int LW     = 3;
    localparam int CW     = $clog2(CH + 1);
    localparam int MAXIDX = (1 << LW) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [CH-1:0]         ch_en;
    logic [CH-1:0]         in_val;
    logic [CH-1:0]         in_rdy;
    logic [CH-1:0]         in_eof;
    logic [CH-1:0][DW-1:0] in_d;
    logic                  out_val;
    logic                  out_rdy;
    logic                  out_eof;
    logic [CW-1:0]         out_ch;
    logic [LW-1:0]         out_idx;
    logic [DW-1:0]         out_d;
    logic                  busy;
    logic                  pkt_done;

    always #5 clk = ~clk;

    multi_dma_stream_arb #(
        .CH (CH),
        .DW (DW),
        .CW (CW),
        .LW (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_eof   (in_eof),
        .in_d     (in_d),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_eof  (out_eof),
        .out_ch   (out_ch),
        .out_idx  (out_idx),
        .out_d    (out_d),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    typedef struct {
        int            ch;
        int            idx;
        logic [DW-1:0] d;
        bit            eof;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: arbitration owner, last winner, beat count, and
    // whether the output register should be holding a beat.
    bit            m_lock  = 1'b0;
    int            m_owner = 0;
    int            m_last  = CH - 1;
    int            m_cnt   = 0;
    bit            m_oval  = 1'b0;
    logic [CH-1:0] m_req;
    logic [CH-1:0] m_exp_rdy;
    beat_t         m_beat;

    // Stimulus source state per channel.
    int            pend    [CH];
    bit            started [CH];
    int            beat_no [CH];
    int            plen    [CH];
    logic [DW-1:0] cur_d   [CH];
    int            val_prob;
    int            rdy_prob;
    int            len_min;
    int            len_max;
    bit            reset_req;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rrRef(input logic [CH-1:0] req, input int last);
        int c;
        for (int k = 1; k <= CH; k++) begin
            c = (last + k) % CH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit chance(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    // Monitor + model: sampled 1 time unit before each rising edge, after
    // inputs have settled for that cycle.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            m_lock = 1'b0;
            m_last = CH - 1;
            m_cnt  = 0;
            m_oval = 1'b0;
            sb.delete();
        end else begin
            m_exp_rdy = '0;
            if (m_lock && (!m_oval || out_rdy)) m_exp_rdy[m_owner] = 1'b1;
            checkOutput("busy", 64'(busy), 64'(m_lock));
            checkOutput("in_rdy", 64'(in_rdy), 64'(m_exp_rdy));
            checkOutput("out_val", 64'(out_val), 64'(m_oval));
            if (m_oval && sb.size() > 0) begin
                checkOutput("out_ch", 64'(out_ch), 64'(sb[0].ch));
                checkOutput("out_idx", 64'(out_idx), 64'(sb[0].idx));
                checkOutput("out_d", 64'(out_d), 64'(sb[0].d));
                checkOutput("out_eof", 64'(out_eof), 64'(sb[0].eof));
                checkOutput("pkt_done", 64'(pkt_done), 64'(out_rdy && sb[0].eof));
                if (out_rdy) begin
                    m_beat = sb.pop_front();
                    m_oval = 1'b0;
                end
            end else begin
                checkOutput("pkt_done_idle", 64'(pkt_done), 64'd0);
            end
            if (m_lock) begin
                if (in_val[m_owner] && m_exp_rdy[m_owner]) begin
                    m_beat.ch  = m_owner;
                    m_beat.idx = (m_cnt > MAXIDX) ? MAXIDX : m_cnt;
                    m_beat.d   = in_d[m_owner];
                    m_beat.eof = in_eof[m_owner];
                    sb.push_back(m_beat);
                    m_oval = 1'b1;
                    m_cnt++;
                    if (in_eof[m_owner]) begin
                        m_lock = 1'b0;
                        m_last = m_owner;
                    end
                end
            end else begin
                m_req = in_val & ch_en;
                if (m_req != '0) begin
                    m_owner = rrRef(m_req, m_last);
                    m_lock  = 1'b1;
                    m_cnt   = 0;
                end
            end
        end
    end

    // Drives one cycle per iteration: packet sources, consumer ready, reset.
    // A source that has started a packet keeps offering it until its eof
    // beat is taken; in_eof/in_d are randomised while in_val is low.
    task automatic applyStimulus(input int cycles);
        logic [CH-1:0] hs;
        repeat (cycles) begin
            @(negedge clk);
            rst_n = !reset_req;
            for (int c = 0; c < CH; c++) begin
                if (!started[c] && pend[c] > 0 && chance(val_prob)) begin
                    started[c] = 1'b1;
                    beat_no[c] = 0;
                    plen[c]    = int'($urandom_range(len_max, len_min));
                    cur_d[c]   = DW'($urandom);
                end
                if (started[c] && chance(val_prob)) begin
                    in_val[c] = 1'b1;
                    in_d[c]   = cur_d[c];
                    in_eof[c] = (beat_no[c] == plen[c] - 1);
                end else begin
                    in_val[c] = 1'b0;
                    in_d[c]   = DW'($urandom);
                    in_eof[c] = 1'($urandom);
                end
            end
            out_rdy = chance(rdy_prob);
            #4;
            hs = in_val & in_rdy;
            if (!rst_n) begin
                hs = '0;
                for (int c = 0; c < CH; c++) begin
                    started[c] = 1'b0;
                    beat_no[c] = 0;
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (hs[c]) begin
                    beat_no[c]++;
                    cur_d[c] = DW'($urandom);
                    if (beat_no[c] == plen[c]) begin
                        started[c] = 1'b0;
                        beat_no[c] = 0;
                        pend[c]--;
                    end
                end
            end
        end
    endtask

    function automatic bit workLeft();
        for (int c = 0; c < CH; c++) begin
            if (pend[c] > 0 || started[c]) return 1'b1;
        end
        return sb.size() != 0;
    endfunction

    initial begin
        int guard;
        rst_n     = 1'b0;
        ch_en     = '1;
        in_val    = '0;
        in_eof    = '0;
        in_d      = '0;
        out_rdy   = 1'b0;
        val_prob  = 100;
        rdy_prob  = 100;
        len_min   = 4;
        len_max   = 4;
        for (int c = 0; c < CH; c++) begin
            pend[c]    = 0;
            started[c] = 1'b0;
            beat_no[c] = 0;
            plen[c]    = 1;
            cur_d[c]   = '0;
        end
        reset_req = 1'b1;
        applyStimulus(3);
        reset_req = 1'b0;

        $display("[TB] single channel 4-beat packet on ch1");
        pend[1] = 1;
        applyStimulus(12);

        $display("[TB] round robin over ch0/ch2/ch4 with 2-beat packets");
        len_min = 2;
        len_max = 2;
        pend[0] = 3;
        pend[2] = 3;
        pend[4] = 3;
        applyStimulus(35);

        $display("[TB] back-pressure on ch3 packets");
        len_min  = 6;
        len_max  = 8;
        rdy_prob = 40;
        pend[3]  = 2;
        applyStimulus(80);

        $display("[TB] ch_en[0] cleared mid-packet");
        rdy_prob = 100;
        len_min  = 8;
        len_max  = 8;
        pend[0]  = 1;
        applyStimulus(3);
        ch_en = 5'b11110;
        applyStimulus(12);
        len_min = 3;
        len_max = 3;
        pend[0] = 1;
        pend[1] = 2;
        applyStimulus(20);

        $display("[TB] beat index saturation with a 10-beat packet");
        ch_en   = '1;
        len_min = 10;
        len_max = 10;
        pend[3] = 1;
        applyStimulus(30);

        $display("[TB] reset in the middle of a packet");
        pend[2] = 1;
        applyStimulus(5);
        reset_req = 1'b1;
        applyStimulus(1);
        reset_req = 1'b0;
        len_min = 2;
        len_max = 5;
        for (int c = 0; c < CH; c++) pend[c] = 1;
        applyStimulus(40);

        $display("[TB] randomised traffic");
        len_min = 1;
        len_max = 12;
        for (int blk = 0; blk < 30; blk++) begin
            ch_en    = CH'($urandom);
            val_prob = int'($urandom_range(90, 30));
            rdy_prob = int'($urandom_range(100, 20));
            for (int c = 0; c < CH; c++) begin
                if (pend[c] == 0) pend[c] = int'($urandom_range(2, 0));
            end
            applyStimulus(50);
        end

        ch_en    = '1;
        val_prob = 100;
        rdy_prob = 100;
        guard    = 0;
        while (workLeft() && guard < 3000) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("drain_timeout", 64'(guard < 3000), 64'd1);
        checkOutput("sb_leftover", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
